// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - widths, FSM states and defaults shared by the mult_arbiter slice
package mult_arb_pkg;
   localparam int XLEN                   = 64;
   localparam int NREQ                   = 2;
   localparam int TIMEOUT_CYCLES_DEFAULT = 64;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

   function automatic logic [NREQ-1:0] sel_onehot(input logic sel);
      return sel ? 2'b10 : 2'b01;
   endfunction
endpackage

// File: rtl/mult_arb_rr_pick.sv
// rtl/mult_arb_rr_pick.sv - combinational 2-way round-robin requester selection
module mult_arb_rr_pick
   import mult_arb_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic            ptr,
   output logic            valid,
   output logic            sel
);
   assign valid = |req;

   // ptr only breaks ties; a lone requester always wins
   always_comb begin
      sel = 1'b0;
      if (req[0] && req[1]) begin
         sel = ptr;
      end else if (req[1]) begin
         sel = 1'b1;
      end
   end
endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - two-requester arbiter in front of one shared multiplier
// Optional WAIT timeout with err flag: define MULT_ARB_TIMEOUT_EN.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
(
   input  logic            clock,
   input  logic            reset_n,
   input  logic [NREQ-1:0] req,
   input  logic [XLEN-1:0] mcand0,
   input  logic [XLEN-1:0] mcand1,
   input  logic [XLEN-1:0] mplier0,
   input  logic [XLEN-1:0] mplier1,
   output logic [NREQ-1:0] gnt,
   output logic [NREQ-1:0] done,
   output logic [XLEN-1:0] product,
   output logic            err,
   output logic            mult_start,
   output logic [XLEN-1:0] mult_mcand,
   output logic [XLEN-1:0] mult_mplier,
   input  logic [XLEN-1:0] mult_product,
   input  logic            mult_done
);
   arb_state_t state, state_nxt;
   logic       sel_q;
   logic       ptr_q;
   logic       mult_done_q;
   logic       pick_valid;
   logic       pick_sel;
   logic       complete;
   logic       timeout;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   mult_arb_rr_pick u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .sel   (pick_sel)
   );

   // Only a fresh edge counts: a done level left over from the last op is ignored
   assign complete = mult_done && !mult_done_q;

`ifdef MULT_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wait_cnt;
   logic          err_q;

   assign timeout = (state == WAIT) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign err     = err_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         wait_cnt <= (state == WAIT) ? wait_cnt + CW'(1) : '0;
         err_q    <= timeout && !complete;
      end
   end
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      gnt       = '0;
      done      = '0;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               gnt       = sel_onehot(pick_sel) & {NREQ{reset_n}};
               state_nxt = ISSUE;
            end
         end
         ISSUE:   state_nxt = WAIT;
         WAIT: begin
            if (complete || timeout) state_nxt = RESP;
         end
         RESP: begin
            done      = sel_onehot(sel_q);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         sel_q       <= 1'b0;
         ptr_q       <= 1'b0;
         mult_done_q <= 1'b0;
         mult_start  <= 1'b0;
         mult_mcand  <= '0;
         mult_mplier <= '0;
         product     <= '0;
      end else begin
         state       <= state_nxt;
         mult_done_q <= mult_done;
         mult_start  <= (state == ISSUE);
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  sel_q       <= pick_sel;
                  mult_mcand  <= pick_sel ? mcand1 : mcand0;
                  mult_mplier <= pick_sel ? mplier1 : mplier0;
               end
            end
            WAIT: begin
               if (complete) begin
                  product <= mult_product;
               end else if (timeout) begin
                  product <= '0;
               end
            end
            RESP:    ptr_q <= ~sel_q;
            default: ;
         endcase
      end
   end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; clock is `clock`, reset is `reset_n`.
REQ-002 Parameter: TIMEOUT_CYCLES, 64, WAIT-state cycle limit before a timeout (used only under MULT_ARB_TIMEOUT_EN).
REQ-003 Port: clock  input  1  system clock.
REQ-004 Port: reset_n  input  1  async active-low reset.
REQ-005 Port: req  input  2  per-requester request level.
REQ-006 Port: mcand0, mcand1  input  64  requester multiplicands.
REQ-007 Port: mplier0, mplier1  input  64  requester multipliers.
REQ-008 Port: gnt  output  2  one-cycle operand-accepted pulse per requester.
REQ-009 Port: done  output  2  one-cycle completion pulse per requester.
REQ-010 Port: product  output  64  result of the last completed operation.
REQ-011 Port: err  output  1  one-cycle timeout flag, coincident with done.
REQ-012 Port: mult_start, mult_mcand, mult_mplier  output  1/64/64  drive the shared mult.
REQ-013 Port: mult_product, mult_done  input  64/1  returned by the shared mult.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; exactly one operation is in flight.
REQ-015 IDLE: if any req bit is high, select one by round-robin, latch its operands into mult_mcand/mult_mplier, pulse gnt[sel], go to ISSUE; otherwise stay.
REQ-016 Round-robin: the pointer resets to requester 0; after each RESP it points to the requester not just served; a lone request is granted regardless of the pointer.
REQ-017 ISSUE: mult_start=1 for exactly one cycle, then go to WAIT.
REQ-018 WAIT: completion is a rising edge of mult_done (high now, low in the previous cycle); a level held over from the prior operation SHALL be ignored.
REQ-019 On completion, mult_product SHALL be captured into product and the FSM SHALL go to RESP.
REQ-020 RESP: done[sel]=1 for one cycle, pointer updated, return to IDLE; gnt is never asserted in RESP.
REQ-021 Latency: gnt to done SHALL be L+3 cycles, where L is the number of cycles from mult_start to the mult_done rising edge.
REQ-022 product SHALL hold its value until the next completion.
REQ-023 Requesters SHALL hold req and operands until gnt; operands may change after gnt without affecting the result.
REQ-024 A req bit dropped before gnt SHALL produce no grant.
REQ-025 Back-to-back: a requester re-asserting req in the done cycle SHALL be eligible in the next IDLE cycle.

Reset
REQ-026 On reset_n=0 (any state, including mid-WAIT), the block SHALL asynchronously enter IDLE.
REQ-027 On reset_n=0, gnt, done, err, mult_start, product, mult_mcand and mult_mplier SHALL all be 0, and the pointer SHALL be 0.
REQ-028 An in-flight operation SHALL be abandoned without a done pulse.

Configuration
REQ-029 With MULT_ARB_TIMEOUT_EN defined, a WAIT cycle counter SHALL run; if TIMEOUT_CYCLES elapse without a mult_done rising edge, the FSM SHALL go to RESP with product=0 and err=1.
REQ-030 Without MULT_ARB_TIMEOUT_EN, WAIT SHALL be unbounded, the counter SHALL be absent, and err SHALL be tied 0.

Structure
REQ-031 Package mult_arb_pkg SHALL hold XLEN=64, NREQ=2, the FSM state enum and the default TIMEOUT_CYCLES.
REQ-032 Sub-module mult_arb_rr_pick SHALL hold the combinational 2-way round-robin selection; the FSM and registers stay in mult_arbiter.
REQ-033 The bench SHALL instantiate the real mult as the shared resource and check each result against a*b.

Verification
REQ-034 Single request: req=01, mcand0=2, mplier0=3 -> gnt[0] pulse, one mult_start, done[0] pulse, product=6, err=0.
REQ-035 Contention: req=11 after reset, mcand0=5/mplier0=50, mcand1=0/mplier1=257 -> requester 0 served first (product=250), then requester 1 (product=0).
REQ-036 Fairness: req=11 held for 4 operations -> grant order 0,1,0,1, and the second mult_start never occurs before the first done.
REQ-037 Width: mcand0=mplier0=FFFF_FFFF_FFFF_FFFF -> product=0000_0000_0000_0001 (low 64 bits).
REQ-038 Reset in WAIT: reset_n=0 for 1 cycle mid-WAIT -> no done pulse, all outputs 0, next request granted to requester 0.
REQ-039 Timeout (MULT_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, mult_done forced low) -> done and err pulse together 8 cycles after WAIT entry, product=0.
